// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter that shares one pipelined external multiplier among NREQ
// requesters and routes each product back to its requester LAT edges after issue.
module mult_rr_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LAT   = 3
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic [WIDTH-1:0]          mul_a,
  output logic [WIDTH-1:0]          mul_b,
  input  logic [2*WIDTH-1:0]        mul_result,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [2*WIDTH-1:0]        rsp_result,
  output logic [$clog2(LAT+1)-1:0]  inflight
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned FW = $clog2(LAT + 1);

  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt_idx;
  logic          gnt_found;
  logic [CW-1:0] cand;
  logic          issue;
  logic          retire;
  logic [LAT-1:0] tag_vld;
  logic [IW-1:0]  tag_idx [LAT];

  // First asserted requester at or after the pointer, wrapping past NREQ-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = {1'b0, ptr} + CW'(off);
      if (cand >= CW'(NREQ)) begin
        cand = cand - CW'(NREQ);
      end
      if (!gnt_found && req_valid[cand[IW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IW-1:0];
      end
    end
  end

  // Grant is suppressed while reset is held so nothing reaches the multiplier.
  always_comb begin
    req_ready = '0;
    if (clr_n && gnt_found) begin
      req_ready = NREQ'(1) << gnt_idx;
    end
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        mul_a = req_a[i*WIDTH +: WIDTH];
        mul_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign issue  = |(req_valid & req_ready);
  assign retire = tag_vld[LAT-1];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ptr <= '0;
    end else if (issue) begin
      ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  // Tag chain mirrors the multiplier pipeline; it never stalls.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tag_vld <= '0;
      for (int unsigned k = 0; k < LAT; k++) begin
        tag_idx[k] <= '0;
      end
    end else begin
      tag_vld[0] <= issue;
      tag_idx[0] <= gnt_idx;
      for (int unsigned k = 1; k < LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      inflight <= '0;
    end else begin
      case ({issue, retire})
        2'b10:   inflight <= inflight + FW'(1);
        2'b01:   inflight <= inflight - FW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_comb begin
    rsp_valid  = '0;
    rsp_result = '0;
    if (retire) begin
      rsp_valid  = NREQ'(1) << tag_idx[LAT-1];
      rsp_result = mul_result;
    end
  end

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed bench for mult_rr_arbiter with a 3-stage multiplier model.
module tb_mult_rr_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned LAT   = 3;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_result;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_result;
  logic [1:0]  inflight;

  logic [7:0]  a_op [4];
  logic [7:0]  b_op [4];
  logic [15:0] mp   [LAT];

  int nvec = 0;
  int nerr = 0;

  int          g_exp  [6] = '{0, 1, 2, 3, 0, 1};
  logic [15:0] r2     [4] = '{16'd10, 16'd22, 16'd36, 16'd52};
  int          if_exp [9] = '{0, 1, 2, 3, 3, 3, 3, 2, 1};
  logic [7:0]  a4     [6] = '{8'd2, 8'd7, 8'd16, 8'd100, 8'd255, 8'd0};
  logic [7:0]  b4     [6] = '{8'd3, 8'd9, 8'd16, 8'd200, 8'd1, 8'd77};
  logic [15:0] p4     [6] = '{16'd6, 16'd63, 16'd256, 16'd20000, 16'd255, 16'd0};

  always #5 clk = ~clk;

  assign req_a = {a_op[3], a_op[2], a_op[1], a_op[0]};
  assign req_b = {b_op[3], b_op[2], b_op[1], b_op[0]};

  // Shared multiplier: operands sampled at an edge, product visible after LAT edges.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int k = 0; k < LAT; k++) mp[k] <= '0;
    end else begin
      mp[0] <= 16'(mul_a) * 16'(mul_b);
      for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
    end
  end
  assign mul_result = mp[LAT-1];

  mult_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .inflight   (inflight)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_n     = 1'b0;
    req_valid = 4'hf;
    for (int i = 0; i < 4; i++) begin
      a_op[i] = 8'(i + 1);
      b_op[i] = 8'(10 + i);
    end

    // Reset state with all requesters asking
    tick();
    chk("rst_ready",    32'(req_ready),  32'd0);
    chk("rst_mul_a",    32'(mul_a),      32'd0);
    chk("rst_mul_b",    32'(mul_b),      32'd0);
    chk("rst_inflight", 32'(inflight),   32'd0);
    chk("rst_rsp",      32'(rsp_valid),  32'd0);
    chk("rst_result",   32'(rsp_result), 32'd0);
    tick();

    // Scenario 1: requester 1, 3*5
    clr_n     = 1'b1;
    req_valid = 4'b0010;
    a_op[1]   = 8'd3;
    b_op[1]   = 8'd5;
    #1;
    chk("s1_ready", 32'(req_ready), 32'b0010);
    chk("s1_mul_a", 32'(mul_a), 32'd3);
    chk("s1_mul_b", 32'(mul_b), 32'd5);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("s1_inflight_e1", 32'(inflight), 32'd1);
    chk("s1_rsp_e1", 32'(rsp_valid), 32'd0);
    tick();
    chk("s1_rsp_e2", 32'(rsp_valid), 32'd0);
    tick();
    chk("s1_rsp_e3",      32'(rsp_valid),  32'b0010);
    chk("s1_result_e3",   32'(rsp_result), 32'd15);
    chk("s1_inflight_e3", 32'(inflight),   32'd1);
    tick();
    chk("s1_rsp_e4",      32'(rsp_valid),  32'd0);
    chk("s1_result_e4",   32'(rsp_result), 32'd0);
    chk("s1_inflight_e4", 32'(inflight),   32'd0);

    // Scenario 3: full-scale operands on requester 3 (pointer now 2)
    a_op[3]   = 8'd255;
    b_op[3]   = 8'd255;
    req_valid = 4'b1000;
    #1;
    chk("s3_ready", 32'(req_ready), 32'b1000);
    chk("s3_mul_a", 32'(mul_a), 32'd255);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    chk("s3_rsp",    32'(rsp_valid),  32'b1000);
    chk("s3_result", 32'(rsp_result), 32'd65025);
    tick();
    chk("s3_inflight", 32'(inflight), 32'd0);

    // Scenario 2: reset, then all four valid
    clr_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_op[i] = 8'(i + 1);
      b_op[i] = 8'(10 + i);
    end
    tick();
    tick();
    clr_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      req_valid = (c < 6) ? 4'hf : 4'h0;
      #1;
      if (c < 6) chk("s2_grant", 32'(req_ready), 32'(4'b0001 << g_exp[c]));
      chk("s2_inflight", 32'(inflight), 32'(if_exp[c]));
      if (c >= 3) begin
        chk("s2_rsp_valid",  32'(rsp_valid),  32'(4'b0001 << g_exp[c-3]));
        chk("s2_rsp_result", 32'(rsp_result), 32'(r2[g_exp[c-3]]));
      end else begin
        chk("s2_rsp_idle", 32'(rsp_valid), 32'd0);
      end
      tick();
    end
    chk("s2_drained", 32'(inflight), 32'd0);

    // Scenario 4: requester 2 streaming fresh operands every cycle
    for (int c = 0; c < 9; c++) begin
      if (c < 6) begin
        req_valid = 4'b0100;
        a_op[2]   = a4[c];
        b_op[2]   = b4[c];
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      if (c < 6) begin
        chk("s4_grant", 32'(req_ready), 32'b0100);
        chk("s4_mul_a", 32'(mul_a), 32'(a4[c]));
      end
      chk("s4_inflight", 32'(inflight), 32'(if_exp[c]));
      if (c >= 3) begin
        chk("s4_rsp_valid",  32'(rsp_valid),  32'b0100);
        chk("s4_rsp_result", 32'(rsp_result), 32'(p4[c-3]));
      end
      tick();
    end
    chk("s4_drained", 32'(inflight), 32'd0);

    // Scenario 5: two in flight, then reset discards them (pointer now 3)
    req_valid = 4'b0011;
    #1;
    chk("s5_grant0", 32'(req_ready), 32'b0001);
    tick();
    chk("s5_grant1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("s5_inflight2", 32'(inflight), 32'd2);
    clr_n = 1'b0;
    #1;
    chk("s5_rst_inflight", 32'(inflight),  32'd0);
    chk("s5_rst_rsp",      32'(rsp_valid), 32'd0);
    tick();
    tick();
    clr_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("s5_no_rsp",   32'(rsp_valid), 32'd0);
      chk("s5_inflight", 32'(inflight),  32'd0);
    end
    req_valid = 4'b1010;
    #1;
    chk("s5_ptr_zero", 32'(req_ready), 32'b0010);
    req_valid = 4'b0000;

    // Scenario 6: idle with junk operands; dropped grant must not move the pointer
    for (int i = 0; i < 4; i++) begin
      a_op[i] = 8'hA5;
      b_op[i] = 8'h5A;
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("s6_ready",    32'(req_ready), 32'd0);
      chk("s6_mul_a",    32'(mul_a),     32'd0);
      chk("s6_mul_b",    32'(mul_b),     32'd0);
      chk("s6_inflight", 32'(inflight),  32'd0);
    end
    req_valid = 4'b1001;
    #1;
    chk("s6_ptr_held", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    chk("s6_rsp",    32'(rsp_valid),  32'b0001);
    chk("s6_result", 32'(rsp_result), 32'd14850);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
